// File: rtl/ecc_pkg.sv
// ecc_pkg: Hsiao H-matrix column generator and error-class enum shared by the SEC-DED pipe.
package ecc_pkg;
  typedef enum logic [1:0] {ECC_CLEAN, ECC_CE_DATA, ECC_CE_CHK, ECC_UE} ecc_class_e;
  function automatic int num_odd_cols(int chk_w);
    int n = 0;
    for (int v = 0; v < (1 << chk_w); v++)
      if ($countones(v) >= 3 && $countones(v) % 2 == 1) n++;
    return n;
  endfunction
  // Data column i is the i-th odd-weight (>=3) value in ascending order; check column j is 1<<j.
  function automatic logic [31:0] h_col(int idx, int data_w, int chk_w);
    logic [31:0] col = '0;
    int n = 0;
    if (idx >= data_w) col = 32'(1) << (idx - data_w);
    else
      for (int v = 0; v < (1 << chk_w); v++)
        if ($countones(v) >= 3 && $countones(v) % 2 == 1) begin
          if (n == idx) col = 32'(v);
          n++;
        end
    return col;
  endfunction
endpackage

// File: rtl/ecc_syn_classify.sv
// ecc_syn_classify: combinational syndrome -> error class, flipped-bit location and data flip mask.
module ecc_syn_classify
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W = 8,
  localparam int LOC_W = $clog2(DATA_W + CHK_W)
) (
  input  logic [CHK_W-1:0]  syn,
  output ecc_class_e        cls,
  output logic [LOC_W-1:0]  loc,
  output logic [DATA_W-1:0] flip
);
  for (genvar i = 0; i < DATA_W; i++) begin : g_hit
    localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(i, DATA_W, CHK_W));
    assign flip[i] = syn == COL;
  end
  assign cls = syn == '0 ? ECC_CLEAN : |flip ? ECC_CE_DATA : $onehot(syn) ? ECC_CE_CHK : ECC_UE;
  always_comb begin
    loc = '0;
    for (int i = 0; i < DATA_W; i++) if (flip[i]) loc = LOC_W'(i);
    for (int j = 0; j < CHK_W; j++) if (syn == CHK_W'(1) << j) loc = LOC_W'(DATA_W + j);
  end
endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: 2-stage SEC-DED decoder/corrector with valid/ready on both sides.
// Define ECC_CNT_EN to build the saturating ce/ue counters; otherwise they read 0.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W = 8,
  parameter int CNT_W = 16,
  localparam int LOC_W = $clog2(DATA_W + CHK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syn,
  output logic              out_ce,
  output logic              out_ue,
  output logic [LOC_W-1:0]  out_loc,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt
);
  if (DATA_W < 4 || num_odd_cols(CHK_W) < DATA_W) begin : g_bad_cfg
    $fatal(1, "ecc_secded_pipe: CHK_W too small for DATA_W");
  end
  logic [CHK_W-1:0] dcol [DATA_W];
  for (genvar i = 0; i < DATA_W; i++) begin : g_col
    localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(i, DATA_W, CHK_W));
    assign dcol[i] = COL;
  end
  logic [CHK_W-1:0] syn;
  always_comb begin
    syn = in_chk;
    for (int i = 0; i < DATA_W; i++) syn = syn ^ (in_data[i] ? dcol[i] : '0);
  end
  logic              s1_valid, s2_valid, rdy_en, s2_adv;
  logic [DATA_W-1:0] s1_data, flip;
  logic [CHK_W-1:0]  s1_syn;
  logic [LOC_W-1:0]  loc;
  ecc_class_e        cls;
  ecc_syn_classify #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_cls (
    .syn (s1_syn),
    .cls (cls),
    .loc (loc),
    .flip(flip)
  );
  assign s2_adv    = !s2_valid | out_ready;
  assign in_ready  = rdy_en & (!s1_valid | s2_adv);
  assign out_valid = s2_valid;
  // rdy_en keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      out_data <= '0;
      out_syn  <= '0;
      out_ce   <= 1'b0;
      out_ue   <= 1'b0;
      out_loc  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (in_ready) s1_valid <= in_valid;
      if (in_ready & in_valid) begin
        s1_data <= in_data;
        s1_syn  <= syn;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv & s1_valid) begin
        out_data <= s1_data ^ flip;
        out_syn  <= s1_syn;
        out_ce   <= cls == ECC_CE_DATA || cls == ECC_CE_CHK;
        out_ue   <= cls == ECC_UE;
        out_loc  <= loc;
      end
    end
`ifdef ECC_CNT_EN
  logic fire;
  assign fire = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else if (cnt_clr) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else begin
      ce_cnt <= ce_cnt + CNT_W'(fire & out_ce & ~&ce_cnt);
      ue_cnt <= ue_cnt + CNT_W'(fire & out_ue & ~&ue_cnt);
    end
`else
  logic cnt_unused;
  assign cnt_unused = cnt_clr;
  assign ce_cnt = '0;
  assign ue_cnt = '0;
`endif
endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: scoreboard bench for ecc_secded_pipe against a table-lookup SEC-DED model.
module tb_ecc_secded_pipe;
`ifdef ECC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CMAX = 3;
  typedef struct {
    logic [31:0] data;
    logic [7:0]  syn;
    logic        ce;
    logic        ue;
    logic [5:0]  loc;
  } exp_t;
  logic        clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_chk, out_syn;
  logic        out_ce, out_ue;
  logic [5:0]  out_loc;
  logic [1:0]  ce_cnt, ue_cnt;
  logic [7:0]  col [40];
  exp_t        exp_q [$];
  int          n_chk = 0, n_fail = 0, mdl_ce = 0, mdl_ue = 0;
  bit          held = 0, done = 0;
  logic [47:0] prev;

  ecc_secded_pipe #(.DATA_W(32), .CHK_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chk(in_chk), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syn(out_syn), .out_ce(out_ce), .out_ue(out_ue),
    .out_loc(out_loc), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [7:0] c);
    exp_t e;
    logic [7:0] s = c;
    int hit = -1;
    for (int i = 0; i < 32; i++) if (d[i]) s ^= col[i];
    for (int k = 0; k < 40; k++) if (col[k] == s) hit = k;
    e.data = d; e.syn = s; e.ce = 0; e.ue = 0; e.loc = 0;
    if (s != 0) begin
      if (hit < 0) e.ue = 1;
      else begin
        e.ce = 1;
        e.loc = 6'(hit);
        if (hit < 32) e.data[hit] = ~e.data[hit];
      end
    end
    return e;
  endfunction

  // Caller is at a falling edge; returns at the falling edge after the handshake.
  task automatic send_exp(input logic [31:0] d, input logic [7:0] c, input exp_t e);
    int t = 0;
    in_valid = 1; in_data = d; in_chk = c;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end else exp_q.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] c);
    send_exp(d, c, model(d, c));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk); t++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      mdl_ce = 0; mdl_ue = 0; held = 0;
    end else begin
      check("ce_cnt", 64'(ce_cnt), 64'(mdl_ce));
      check("ue_cnt", 64'(ue_cnt), 64'(mdl_ue));
      if (held) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_hold", 64'({out_data, out_syn, out_ce, out_ue, out_loc}), 64'(prev));
      end
      held = out_valid & !out_ready;
      prev = {out_data, out_syn, out_ce, out_ue, out_loc};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got data %0h expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_syn", 64'(out_syn), 64'(e.syn));
          check("out_ce", 64'(out_ce), 64'(e.ce));
          check("out_ue", 64'(out_ue), 64'(e.ue));
          check("out_loc", 64'(out_loc), 64'(e.loc));
          if (CNT_EN && e.ce && mdl_ce < CMAX) mdl_ce++;
          if (CNT_EN && e.ue && mdl_ue < CMAX) mdl_ue++;
        end
      end
      if (CNT_EN && cnt_clr) begin
        mdl_ce = 0; mdl_ue = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  c;
    int n, p;
    begin
      int k = 0;
      for (int v = 1; v < 256; v++)
        if ($countones(v) >= 3 && $countones(v) % 2 == 1 && k < 32) begin
          col[k] = 8'(v); k++;
        end
      for (int j = 0; j < 8; j++) col[32+j] = 8'(1 << j);
    end
    rst_n = 0; in_valid = 0; in_data = 0; in_chk = 0; out_ready = 1; cnt_clr = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_ce_cnt", 64'(ce_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    send_exp(32'h0, 8'h00, '{data: 32'h0, syn: 8'h00, ce: 0, ue: 0, loc: 6'd0});
    send_exp(32'h1, 8'h00, '{data: 32'h0, syn: 8'h07, ce: 1, ue: 0, loc: 6'd0});
    send_exp(32'h0, 8'h20, '{data: 32'h0, syn: 8'h20, ce: 1, ue: 0, loc: 6'd37});
    send_exp(32'h3, 8'h00, '{data: 32'h3, syn: 8'h0C, ce: 0, ue: 1, loc: 6'd0});
    drain();
    #1;
    check("ce_cnt_two", 64'(ce_cnt), CNT_EN ? 64'd2 : 64'd0);
    check("ue_cnt_one", 64'(ue_cnt), CNT_EN ? 64'd1 : 64'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) send(32'h1 << (k * 5), 8'h00);
    drain();
    #1;
    check("ce_cnt_sat", 64'(ce_cnt), CNT_EN ? 64'd3 : 64'd0);
    @(negedge clk);
    cnt_clr = 1;
    send(32'h80, 8'h00);
    drain();
    cnt_clr = 0;
    #1;
    check("ce_cnt_clr", 64'(ce_cnt), 0);
    @(negedge clk);
    fork
      for (int k = 0; k < 8; k++) send($urandom, 8'($urandom));
      begin
        repeat (3) @(negedge clk);
        out_ready = 0;
        repeat (4) @(negedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        out_ready = 1;
      end
    join
    drain();
    send(32'h4, 8'h00);
    drain();
    out_ready = 0;
    send($urandom, 8'($urandom));
    send($urandom, 8'($urandom));
    #3;
    rst_n = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_ce_cnt", 64'(ce_cnt), 0);
    check("midrst_ue_cnt", 64'(ue_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    #1;
    check("midrst_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    fork
      begin
        for (int w = 0; w < 300; w++) begin
          d = $urandom; c = 0;
          for (int i = 0; i < 32; i++) if (d[i]) c ^= col[i];
          n = $urandom_range(0, 2);
          for (int k = 0; k < n; k++) begin
            p = $urandom_range(0, 39);
            if (p < 32) d[p] = ~d[p];
            else c[p-32] = ~c[p-32];
          end
          send(d, c);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = $urandom_range(0, 9) < 7;
          cnt_clr = $urandom_range(0, 19) == 0;
        end
        out_ready = 1;
        cnt_clr = 0;
      end
    join
    drain();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ecc_secded_pipe.md
# ecc_secded_pipe

Parametrised, pipelined SEC-DED decoder/corrector for the memory read path. It takes a data word plus its check bits and computes the syndrome against a fixed Hsiao H-matrix. It corrects any single-bit error (data or check), flags uncorrectable errors and reports the error location. It sits between the memory read port and the load/store unit, with a valid/ready handshake on both sides and optional saturating error counters.

## Interface
- DATA_W, 32, data word width (≥ 4)
- CHK_W, 8, check-bit width; elaboration fails if the odd-weight (≥3) CHK_W-bit codes number fewer than DATA_W
- CNT_W, 16, error-counter width
- LOC_W, $clog2(DATA_W+CHK_W), location index width (derived, not overridable)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- in_data  in  DATA_W  raw data read from memory
- in_chk  in  CHK_W  stored check bits
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  corrected data
- out_syn  out  CHK_W  syndrome of this word
- out_ce  out  1  single error corrected (data or check bit)
- out_ue  out  1  uncorrectable error; out_data = in_data unmodified
- out_loc  out  LOC_W  flipped bit index: 0..DATA_W-1 data, DATA_W+j check bit j; 0 when !out_ce
- cnt_clr  in  1  synchronous clear of both counters
- ce_cnt  out  CNT_W  corrected-error count
- ue_cnt  out  CNT_W  uncorrectable-error count

## Operation
- H-matrix: data bit i column = i-th odd-weight (≥3) CHK_W-bit value in ascending numeric order (DATA_W=32, CHK_W=8: bit0=8'h07, bit1=8'h0B, bit2=8'h0D, bit3=8'h0E, bit4=8'h13). Check bit j column = 1<<j.
- Syndrome = XOR of the columns of all set bits of {in_chk, in_data}.
- Classification:
  - syn==0: clean; ce=0, ue=0.
  - syn equals data column i: flip data bit i; ce=1, loc=i.
  - syn one-hot bit j: ce=1, loc=DATA_W+j, data unchanged.
  - any other syn (even weight, or odd weight with no column match): ue=1, ce=0, loc=0.
- Stage 1 registers in_data and the syndrome. Stage 2 registers the classification, corrected data and location.
- Counters increment once per word accepted on the output handshake (out_valid & out_ready) with ce/ue set. They saturate at all-ones.
- cnt_clr has priority over an increment in the same cycle; result 0.

## Timing
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput: 1 word/cycle.
- A stage loads when it is empty or the stage after it is advancing; in_ready = !s1_valid | s1_advance. Fully registered outputs, so no combinational in→out path except ready.
- out_valid stays high and all out_* stay stable until out_ready is sampled high.
- Reset (async, any time, including mid-pipeline): both stage valids clear, in-flight words are dropped, all outputs 0, counters 0. in_ready goes to 1 on the first edge after rst_n deasserts.
- Simultaneous input and output handshake with both stages full: the pipeline shifts, no bubble and no loss.

## Configuration
- ECC_CNT_EN defined: ce_cnt/ue_cnt registers and cnt_clr logic are present as specified.
- Not defined: no counter flops; ce_cnt and ue_cnt tie to 0 and cnt_clr is ignored. Datapath behaviour is identical.

## Structure
- Package ecc_pkg: function returning the H column for a given index/DATA_W/CHK_W, and the error-class enum {ECC_CLEAN, ECC_CE_DATA, ECC_CE_CHK, ECC_UE}.
- One sub-module ecc_syn_classify: combinational syndrome → {class, loc, flip mask}, instantiated in stage 2.

## Test plan
- in_data=32'h0, in_chk=8'h00 → after 2 cycles out_data=0, out_syn=0, ce=0, ue=0.
- in_data=32'h1, in_chk=8'h00 (bit0 flipped from a clean all-zero word) → syn=8'h07, out_data=0, ce=1, loc=0; ce_cnt=1.
- in_data=0, in_chk=8'h20 → syn=8'h20, ce=1, loc=37, out_data=0.
- in_data=32'h3, in_chk=0 → syn=8'h0C (even weight), ue=1, out_data=32'h3, ue_cnt=1.
- 8 back-to-back words with out_ready held low for 5 cycles mid-stream → in_ready drops after 2 words are buffered. All 8 words emerge in order with none lost or duplicated, and outputs are stable during the stall.
- ECC_CNT_EN defined, CNT_W=2, 5 CE words → ce_cnt saturates at 3. cnt_clr asserted together with a CE handshake → ce_cnt=0. rst_n pulsed while 2 words are in flight → out_valid=0 and both counters=0.
